// File: rtl/bank_sum_pkg.sv
// Shared constants and types for the bank read / row-sum stage.
// Bank geometry, FSM states and the {sum,last} record held by the output buffer.
package bank_sum_pkg;

  localparam int NBANK  = 10;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int SUM_W  = 20;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [SUM_W-1:0] sum;
    logic             last;
  } row_t;

  function automatic logic [SUM_W-1:0] sext_word(input logic [DATA_W-1:0] w);
    return {{(SUM_W-DATA_W){w[DATA_W-1]}}, w};
  endfunction

endpackage

// File: rtl/sum_fifo2.sv
// Two-entry FIFO of {sum,last} rows with occupancy count and registered valid.
// The head entry is presented directly from storage, so it is stable until popped.
module sum_fifo2
  import bank_sum_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  row_t       push_row,
  input  logic       pop,
  output row_t       head,
  output logic [1:0] count,
  output logic       valid
);

  row_t       mem_q [FIFO_DEPTH];
  row_t       mem_d [FIFO_DEPTH];
  logic       rd_ptr_q, rd_ptr_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic [1:0] count_q, count_d;
  logic       valid_q, valid_d;
  logic       pop_ok, push_ok;

  assign pop_ok  = pop & valid_q;
  assign push_ok = push & ((count_q != 2'd2) | pop_ok);

  // NOTE: every variable gets its default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q ^ pop_ok;
    wr_ptr_d = wr_ptr_q ^ push_ok;
    count_d  = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    valid_d  = (count_d != 2'd0);
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_row;
    end
  end

  // NOTE: storage is reset too, because the head entry drives out_sum/out_last and those must read 0 after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      valid_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign valid = valid_q;

endmodule

// File: rtl/bank_sum_reader.sv
// Walks a row range across ten parallel SRAM banks, sums each row as signed words
// and streams the sums over valid/ready through a 2-entry buffer.
module bank_sum_reader
  import bank_sum_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [ADDR_W-1:0]       length,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       sram_address,
  input  logic [NBANK*DATA_W-1:0] sram_rdata,
  output logic [SUM_W-1:0]        out_sum,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] cur_addr;
  logic [2:0]        occupancy;
  logic              pop, credit_ok, issue, last_issue;
  logic [SUM_W-1:0]  row_sum;
  row_t              push_row, head;
  logic [1:0]        fifo_count;
  logic              fifo_valid;

  assign pop        = fifo_valid & out_ready;
  assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight_q};
  // A pop is only possible with a buffered row, so occupancy - pop never underflows.
  assign credit_ok  = (occupancy - {2'b00, pop}) < 3'd2;
  assign issue      = (state_q == ISSUE) && credit_ok;
  assign last_issue = issue && (row_q == len_q - ADDR_W'(1));
  assign cur_addr   = base_q + row_q;

  // The address is presented in the issue cycle itself; otherwise the bus holds the last one.
  assign sram_address = issue ? cur_addr : addr_q;

  // NOTE: blocking '=' accumulates inside always_comb; sequential state below only ever uses '<='.
  always_comb begin
    row_sum = '0;
    for (int k = 0; k < NBANK; k++) begin
      row_sum = row_sum + sext_word(sram_rdata[k*DATA_W +: DATA_W]);
    end
  end

  always_comb begin
    push_row.sum  = row_sum;
    push_row.last = inflight_last_q;
  end

  always_comb begin
    state_d         = state_q;
    base_d          = base_q;
    len_d           = len_q;
    row_d           = row_q;
    done_d          = 1'b0;
    addr_d          = issue ? cur_addr : addr_q;
    inflight_d      = issue;
    inflight_last_d = last_issue;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            base_d  = base_addr;
            len_d   = length;
            row_d   = '0;
            state_d = ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (issue) begin
          row_d = row_q + ADDR_W'(1);
          if (last_issue) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && head.last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      base_q          <= '0;
      len_q           <= '0;
      row_q           <= '0;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      base_q          <= base_d;
      len_q           <= len_d;
      row_q           <= row_d;
      addr_q          <= addr_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
    end
  end

  sum_fifo2 u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (inflight_q),
    .push_row (push_row),
    .pop      (pop),
    .head     (head),
    .count    (fifo_count),
    .valid    (fifo_valid)
  );

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign out_sum   = head.sum;
  assign out_last  = head.last;
  assign out_valid = fifo_valid;

endmodule

// File: tb/tb_bank_sum_reader.sv
// Randomized scoreboard bench for bank_sum_reader with a behavioural bank/row-sum model.
module tb_bank_sum_reader;
  import bank_sum_pkg::*;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    start = 1'b0;
  logic [ADDR_W-1:0]       base_addr = '0;
  logic [ADDR_W-1:0]       length = '0;
  logic                    busy, done;
  logic [ADDR_W-1:0]       sram_address;
  logic [NBANK*DATA_W-1:0] sram_rdata = '0;
  logic [SUM_W-1:0]        out_sum;
  logic                    out_last, out_valid;
  logic                    out_ready = 1'b0;

  bank_sum_reader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .length       (length),
    .busy         (busy),
    .done         (done),
    .sram_address (sram_address),
    .sram_rdata   (sram_rdata),
    .out_sum      (out_sum),
    .out_last     (out_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Bank contents: 0 -> word = addr+bank, 1 -> 0x8000, 2 -> 0x7FFF, 3 -> random table
  int          data_mode = 0;
  logic [15:0] rnd_tab [NBANK][256];

  function automatic logic [15:0] word_bits(input logic [15:0] a, input int k);
    case (data_mode)
      0:       return a + 16'(k);
      1:       return 16'h8000;
      2:       return 16'h7FFF;
      default: return rnd_tab[k][a[7:0]];
    endcase
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < NBANK; k++) begin
      sram_rdata[k*DATA_W +: DATA_W] <= word_bits(sram_address, k);
    end
  end

  // Ready pattern: 0 always 1, 1 repeating 1,0,0,1,0,1, 2 random, 3 always 0
  int ready_mode = 3;
  int pat_idx = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: begin
        out_ready = (pat_idx == 0 || pat_idx == 3 || pat_idx == 5);
        pat_idx   = (pat_idx + 1) % 6;
      end
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  typedef struct {
    int sum;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   exp_done[$];

  function automatic int row_model(input logic [15:0] a);
    int s = 0;
    for (int k = 0; k < NBANK; k++) begin
      s += int'($signed(word_bits(a, k)));
    end
    return s;
  endfunction

  // Monitor: scoreboard pops, done timing, stall stability.
  bit               prev_stall = 0;
  logic [SUM_W-1:0] prev_sum;
  logic             prev_last;

  always @(negedge clk) begin
    bit   done_now;
    exp_t e;
    if (!reset) begin
      prev_stall = 0;
    end else begin
      done_now = (exp_done.size() > 0 && exp_done[0] == cyc);
      if (done_now) void'(exp_done.pop_front());
      check("done", done, done_now);
      if (done_now) check("busy_low_at_done", busy, 0);
      if (prev_stall) begin
        check("stall_valid_held", out_valid, 1);
        check("stall_sum_stable", out_sum, prev_sum);
        check("stall_last_stable", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL extra_row at cycle %0d: got sum %0d, expected no row", cyc, $signed(out_sum));
        end else begin
          e = exp_q.pop_front();
          check("row_sum", $signed(out_sum), e.sum);
          check("row_last", out_last, e.last);
          if (e.last) exp_done.push_back(cyc + 1);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_sum   = out_sum;
      prev_last  = out_last;
    end
  end

  // Issues a command in cycle c (returned) and records the expected rows/done.
  task automatic issue_cmd(input logic [15:0] b, input logic [15:0] l, output int c);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = b;
    length    = l;
    c         = cyc;
    for (int i = 0; i < int'(l); i++) begin
      exp_t e;
      e.sum  = row_model(b + 16'(i));
      e.last = (i == int'(l) - 1);
      exp_q.push_back(e);
    end
    if (l == 0) exp_done.push_back(c + 1);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0 && exp_done.size() == 0) begin
        ok = 1;
        break;
      end
    end
    check("idle_reached", ok, 1);
    @(negedge clk);
  endtask

  initial begin
    int c;
    for (int k = 0; k < NBANK; k++)
      for (int j = 0; j < 256; j++)
        rnd_tab[k][j] = 16'($urandom);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_addr", sram_address, 0);
    check("rst_valid", out_valid, 0);
    check("rst_sum", out_sum, 0);
    check("rst_last", out_last, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Nominal run: address sequence and first-valid latency
    data_mode  = 0;
    ready_mode = 0;
    issue_cmd(16'd4, 16'd3, c);
    @(negedge clk);
    check("nom_addr0", sram_address, 4);
    @(negedge clk);
    check("nom_addr1", sram_address, 5);
    check("nom_valid_c2", out_valid, 0);
    @(negedge clk);
    check("nom_addr2", sram_address, 6);
    check("nom_valid_c3", out_valid, 1);
    check("nom_first_sum", out_sum, 85);
    wait_idle(50);

    // Backpressure with the 1,0,0,1,0,1 ready pattern
    ready_mode = 1;
    pat_idx    = 0;
    issue_cmd(16'd4, 16'd5, c);
    wait_idle(100);

    // Signed extremes
    ready_mode = 0;
    data_mode  = 1;
    issue_cmd(16'd100, 16'd2, c);
    wait_idle(50);
    data_mode = 2;
    issue_cmd(16'd7, 16'd3, c);
    wait_idle(50);

    // Address wrap
    data_mode = 0;
    issue_cmd(16'hFFFF, 16'd2, c);
    @(negedge clk);
    check("wrap_addr0", sram_address, 16'hFFFF);
    @(negedge clk);
    check("wrap_addr1", sram_address, 16'h0000);
    wait_idle(50);

    // Zero length: done one cycle later, no busy, no rows
    issue_cmd(16'd20, 16'd0, c);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("zero_busy", busy, 0);
      check("zero_valid", out_valid, 0);
    end
    wait_idle(20);

    // Start while busy adds no rows
    ready_mode = 2;
    issue_cmd(16'd10, 16'd3, c);
    @(posedge clk);
    #1;
    start     = 1'b1;
    base_addr = 16'd200;
    length    = 16'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle(100);

    // Reset in DRAIN with a full buffer
    ready_mode = 3;
    issue_cmd(16'd30, 16'd2, c);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_valid", out_valid, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    exp_done.delete();
    @(negedge clk);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_addr", sram_address, 0);
    @(posedge clk);
    #1;
    reset      = 1'b1;
    ready_mode = 0;
    @(negedge clk);
    check("post_rst_done", done, 0);
    check("post_rst_busy", busy, 0);
    issue_cmd(16'd4, 16'd3, c);
    wait_idle(50);

    // Randomized commands
    data_mode = 3;
    for (int n = 0; n < 25; n++) begin
      logic [15:0] b;
      logic [15:0] l;
      ready_mode = $urandom_range(0, 2);
      b = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFF - 16'($urandom_range(0, 3))) : 16'($urandom);
      l = 16'($urandom_range(1, 7));
      issue_cmd(b, l, c);
      wait_idle(400);
    end

    check("rows_left", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
